// File: rtl/axis_uart_pkg.sv
// Shared types and helpers for the UART-to-AXIS source path.
// Holds default sizes, the level-width function and the handshake rule.
package axis_uart_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Occupancy type for the default FIFO depth.
    typedef logic [level_w(DEF_DEPTH)-1:0] level_t;

    // A valid/ready transfer completes when both sides agree in one cycle.
    function automatic logic hs_fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one async read.
// Contents are not reset; occupancy tracking lives in the owner.
module axis_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the incoming word on a write strobe.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_master_fifo.sv
// AXI-Stream master source stage with a DEPTH-entry first-word-fall-through FIFO.
// Define AXIS_MASTER_FIFO_TLAST_EN to generate TLAST every PKT_LEN beats.
module axis_master_fifo
    import axis_uart_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int PKT_LEN = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_valid,
    input  logic [WIDTH-1:0]            load_data,
    output logic                        load_ready,
    output logic                        m_axis_tvalid,
    output logic [WIDTH-1:0]            m_axis_tdata,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [level_w(DEPTH)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] rdata;
    logic             wr_fire;
    logic             rd_fire;

    // Ready depends only on the registered level, never on tready.
    assign load_ready    = (level != LVL_FULL);
    assign m_axis_tvalid = (level != '0);
    // Zero the bus while empty so reset shows a clean 0.
    assign m_axis_tdata  = m_axis_tvalid ? rdata : '0;

    assign wr_fire = hs_fire(load_valid, load_ready);
    assign rd_fire = hs_fire(m_axis_tvalid, m_axis_tready);

    axis_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr),
        .wdata (load_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Advance pointers on their handshakes; level tracks net occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_fire, rd_fire})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

`ifdef AXIS_MASTER_FIFO_TLAST_EN
    localparam int CW = $clog2(PKT_LEN) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [CW-1:0] beat_cnt;

    assign m_axis_tlast = m_axis_tvalid && (beat_cnt == LAST_BEAT);

    // Count completed beats; wrap after the beat that carried TLAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (rd_fire) begin
            beat_cnt <= m_axis_tlast ? '0 : beat_cnt + CNT_ONE;
        end
    end
`else
    assign m_axis_tlast = 1'b0;
`endif

endmodule

// File: doc/axis_master_fifo.md
Name: axis_master_fifo

Overview:
- Parametrised AXI-Stream master source stage.
- Accepts words on a valid/ready load port and buffers them in a DEPTH-entry FIFO.
- Presents them on an AXIS-compliant master port: tvalid is held with tdata stable until tready.
- Sits between the UART RX byte assembler and any downstream AXIS consumer; replaces the single-register capture stage, which dropped data under backpressure.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, FIFO entries; must be a power of two, >=2.
- PKT_LEN, 16, beats per packet for TLAST generation (>=1); used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  producer has a word on load_data.
- load_data  in  WIDTH  word to enqueue.
- load_ready  out  1  FIFO can accept a word this cycle.
- m_axis_tvalid  out  1  head word valid.
- m_axis_tdata  out  WIDTH  head word.
- m_axis_tready  in  1  consumer accepts the head word.
- m_axis_tlast  out  1  last beat of packet (tied 0 without the optional feature).
- level  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n low, async assert, sync release): wr_ptr=rd_ptr=0, level=0, m_axis_tvalid=0, m_axis_tlast=0, load_ready=1, m_axis_tdata=0. Memory contents need no reset.
- Reset mid-operation discards all buffered words immediately. No output handshake completes in a cycle where rst_n is low.
- Write fires when load_valid && load_ready. load_data is stored at mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Read fires when m_axis_tvalid && m_axis_tready; rd_ptr increments modulo DEPTH.
- Pointers are $clog2(DEPTH) bits with natural wrap; full/empty are decided by the level counter.
- Level update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on simultaneous write+read, or on neither.
- load_ready = (level != DEPTH). It is combinational from registered level only; there is no path from m_axis_tready.
- When full, a write is refused even if a read fires in the same cycle; the word is accepted next cycle.
- m_axis_tvalid = (level != 0).
- m_axis_tdata = mem[rd_ptr], first-word-fall-through. It must be stable while tvalid=1 && tready=0.
- Latency: a word written at edge N appears on m_axis at edge N (visible in cycle N+1) when the FIFO was empty. Minimum 1 cycle, load to output.
- Once asserted, tvalid never deasserts without a completed handshake, except on reset.
- Empty + simultaneous load: no read (tvalid=0); level becomes 1.
- Sustained throughput: 1 word/cycle while neither full nor empty.

Optional Feature:
- Macro: AXIS_MASTER_FIFO_TLAST_EN.
- Defined:
  - A beat counter (width $clog2(PKT_LEN)+1) counts completed output handshakes.
  - m_axis_tlast = 1 when the counter equals PKT_LEN-1 and tvalid=1.
  - On a handshake with tlast=1 the counter returns to 0; otherwise it increments on each handshake.
  - Reset clears the counter.
  - PKT_LEN=1 gives tlast=1 on every beat.
- Undefined: m_axis_tlast is constant 0 and no counter logic is present.

Decomposition:
- Shared package axis_uart_pkg:
  - default WIDTH/DEPTH constants
  - a clog2-based level-width function
  - the handshake-fire expressions as documented constants/typedef for level.
- Sub-module axis_fifo_mem: DEPTH×WIDTH register array with a write port (we, waddr, wdata) and an async read port (raddr → rdata).
- Pointers, level, handshake and TLAST logic stay in the top.

Test Plan:
- Reset: drive rst_n=0 with load_valid=1 -> tvalid=0, level=0, load_ready=1. Release, write 0xA5 -> tvalid=1, tdata=0xA5 next cycle.
- Backpressure fill: tready=0, write 0x01..0x04 (DEPTH=4) -> level=4, load_ready=0. A fifth word 0x05 held on load is not taken. tdata stays 0x01.
- Drain order: from full, tready=1 -> tdata 0x01,0x02,0x03,0x04 on consecutive cycles, then tvalid=0, level=0.
- Simultaneous: level=2, load_valid=1 and tready=1 for 10 cycles -> level stays 2 and output order matches input order. When full with tready=1, the write is refused that cycle and level drops to 3.
- Reset mid-stream: level=3, assert rst_n=0 asynchronously between edges -> tvalid falls immediately. After release, level=0 and the old data is not re-emitted.
- TLAST (macro defined, PKT_LEN=4): stream 8 words with tready toggling -> tlast high exactly on beats 4 and 8. Without the macro, tlast=0 throughout.
